// File: rtl/mips_pkg.sv
`default_nettype none
// Shared MIPS pipeline definitions: fetch FSM state type and architectural constants.
package mips_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    READY = 1'b1
  } fetch_state_t;

  localparam logic [31:0] MIPS_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] MIPS_PC_STEP   = 32'd4;
  localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// if_fetch_unit: IF stage; owns the PC, fetches over a req/ack handshake with
// variable-latency imem, redirects on taken branches and squashes in-flight fetches.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] PC_STEP   = MIPS_PC_STEP,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        fetch_busy
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  tgt, tgt_nxt;
  logic         squash, squash_nxt;
  logic [31:0]  inst_buf, inst_buf_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tgt      <= RESET_PC;
      squash   <= 1'b0;
      inst_buf <= NOP_INSTR;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      tgt      <= tgt_nxt;
      squash   <= squash_nxt;
      inst_buf <= inst_buf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    tgt_nxt      = tgt;
    squash_nxt   = squash;
    inst_buf_nxt = inst_buf;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          // A branch arriving with the ack is newer than any pending target.
          if (br_taken) begin
            pc_nxt     = br_addr;
            squash_nxt = 1'b0;
          end else if (squash) begin
            pc_nxt     = tgt;
            squash_nxt = 1'b0;
          end else begin
            inst_buf_nxt = imem_rdata;
            state_nxt    = READY;
          end
        end else if (br_taken) begin
          // The open transaction must complete at its original address first.
          squash_nxt = 1'b1;
          tgt_nxt    = br_addr;
        end
      end
      READY: begin
        if (br_taken) begin
          pc_nxt    = br_addr;
          state_nxt = FETCH;
        end else if (!freeze) begin
          pc_nxt    = pc + PC_STEP;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Request is gated by rst so it drops the moment reset asserts.
  assign imem_req        = (state == FETCH) && !rst;
  assign imem_addr       = pc;
  assign pc_out          = pc + PC_STEP;
  assign instruction_out = (state == READY) ? inst_buf : NOP_INSTR;
  assign fetch_busy      = (state == FETCH);

  ack_only_with_req: assert property (@(posedge clk) disable iff (rst) imem_ack |-> imem_req);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Testbench for if_fetch_unit: directed vector table, hand sequences, and a
// randomized run against a behavioural fetch model with a variable-latency memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_busy;

  int n_pass  = 0;
  int n_total = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .br_taken        (br_taken),
    .br_addr         (br_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_busy      (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pcout;
    logic [31:0] e_instr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [97:0] pack(input logic req, input logic [31:0] addr,
                                       input logic [31:0] pco, input logic [31:0] ins,
                                       input logic busy);
    return {req, addr, pco, ins, busy};
  endfunction

  function automatic logic [97:0] dut_out();
    return {imem_req, imem_addr, pc_out, instruction_out, fetch_busy};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [97:0] got, input logic [97:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic frz, input logic br, input logic [31:0] baddr,
                     input logic ack, input logic [31:0] rdata,
                     input logic req, input logic [31:0] addr, input logic [31:0] pco,
                     input logic [31:0] ins, input logic busy);
    vec_t v;
    v = '{frz, br, baddr, ack, rdata, req, addr, pco, ins, busy};
    vecs.push_back(v);
  endtask

  task automatic set_in(input logic frz, input logic br, input logic [31:0] baddr,
                        input logic ack, input logic [31:0] rdata);
    freeze = frz; br_taken = br; br_addr = baddr; imem_ack = ack; imem_rdata = rdata;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_buf, m_tgt;
  logic        m_valid, m_redir;
  logic        mem_pend;
  int          mem_lat;
  logic [31:0] mem_addr;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_state", dut_out(), pack(0, 32'h0, 32'h4, 32'h0, 1));
    rst = 1'b0;
    #1;

    // fr br baddr ack rdata | req addr pc_out instr busy
    add(0,0,0,          0,0,            1,32'h0,  32'h4,  32'h0,         1);
    add(0,0,0,          1,32'h2001_0005,1,32'h0,  32'h4,  32'h0,         1);
    for (int i = 0; i < 5; i++)
      add(1,0,0,        0,0,            0,32'h0,  32'h4,  32'h2001_0005, 0);
    add(0,0,0,          0,0,            0,32'h0,  32'h4,  32'h2001_0005, 0);
    add(0,0,0,          1,32'h1111,     1,32'h4,  32'h8,  32'h0,         1);
    add(0,0,0,          0,0,            0,32'h4,  32'h8,  32'h1111,      0);
    add(0,0,0,          0,0,            1,32'h8,  32'hC,  32'h0,         1);
    add(0,0,0,          1,32'h2222,     1,32'h8,  32'hC,  32'h0,         1);
    add(1,1,32'h80,     0,0,            0,32'h8,  32'hC,  32'h2222,      0);
    add(0,1,32'h40,     0,0,            1,32'h80, 32'h84, 32'h0,         1);
    add(0,1,32'hC0,     0,0,            1,32'h80, 32'h84, 32'h0,         1);
    add(0,0,0,          1,32'hDEAD,     1,32'h80, 32'h84, 32'h0,         1);
    add(0,1,32'h100,    1,32'hBEEF,     1,32'hC0, 32'hC4, 32'h0,         1);
    add(0,0,0,          1,32'h3333,     1,32'h100,32'h104,32'h0,         1);
    add(1,0,0,          0,0,            0,32'h100,32'h104,32'h3333,      0);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d", i), dut_out(),
            pack(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pcout, vecs[i].e_instr, vecs[i].e_busy));
      set_in(vecs[i].frz, vecs[i].br, vecs[i].baddr, vecs[i].ack, vecs[i].rdata);
      tick();
      set_in(0, 0, 0, 0, 0);
    end

    // Reset asserted while a fetch is outstanding
    tick();
    check("pending_fetch", dut_out(), pack(1, 32'h104, 32'h108, 32'h0, 1));
    #3 rst = 1'b1;
    #1 check("reset_mid_fetch", dut_out(), pack(0, 32'h0, 32'h4, 32'h0, 1));
    tick();
    rst = 1'b0;
    #1 check("refetch_after_reset", dut_out(), pack(1, 32'h0, 32'h4, 32'h0, 1));

    // PC wrap at top of address space
    set_in(0, 0, 0, 1, 32'h7777); tick();
    set_in(0, 1, 32'hFFFF_FFFC, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    check("wrap_fetch", dut_out(), pack(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1));
    set_in(0, 0, 0, 1, 32'h4444); tick();
    set_in(0, 0, 0, 0, 0);
    check("wrap_ready", dut_out(), pack(0, 32'hFFFF_FFFC, 32'h0, 32'h4444, 0));
    tick();
    check("wrap_next", dut_out(), pack(1, 32'h0, 32'h4, 32'h0, 1));

    // Randomized run against the behavioural model
    rst = 1'b1; tick(); rst = 1'b0; #1;
    m_pc = 32'h0; m_buf = 32'h0; m_tgt = 32'h0; m_valid = 0; m_redir = 0;
    mem_pend = 0; mem_lat = 0; mem_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        fr, br, ack;
      logic [31:0] ba, rd;
      check("rand_cycle", dut_out(),
            pack(!m_valid, m_pc, m_pc + 32'd4, m_valid ? m_buf : 32'h0, !m_valid));
      if (m_valid)
        check("rand_instr_matches_pc", {66'b0, instruction_out}, {66'b0, mem_word(pc_out - 32'd4)});
      fr = ($urandom % 3) == 0;
      br = ($urandom % 7) == 0;
      ba = $urandom & 32'hFFFF_FFFC;
      ack = 1'b0;
      rd = $urandom;
      if (imem_req) begin
        if (!mem_pend) begin
          mem_pend = 1'b1;
          mem_lat  = $urandom_range(0, 3);
          mem_addr = imem_addr;
        end else begin
          check("rand_addr_stable", {66'b0, imem_addr}, {66'b0, mem_addr});
        end
        if (mem_lat == 0) begin
          ack = 1'b1;
          rd  = mem_word(mem_addr);
          mem_pend = 1'b0;
        end else begin
          mem_lat--;
        end
      end
      set_in(fr, br, ba, ack, rd);
      tick();
      if (!m_valid) begin
        if (ack) begin
          if (br)           begin m_pc = ba;    m_redir = 0; end
          else if (m_redir) begin m_pc = m_tgt; m_redir = 0; end
          else              begin m_valid = 1;  m_buf = rd;  end
        end else if (br) begin
          m_redir = 1; m_tgt = ba;
        end
      end else if (br) begin
        m_pc = ba; m_valid = 0;
      end else if (!fr) begin
        m_pc = m_pc + 32'd4; m_valid = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
